// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch PC, imem requester and instruction FIFO; FETCH_PREDECODE_EN folds unconditional branches
module instruction_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [31:0]     fetch_instr,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fetch_folded,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_W-1:0] pc_q, pc_d, addr_q, addr_d, next_pc;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic drop_q, drop_d, pop, push, acc, fold;
  logic [31:0] instr_q [DEPTH];
  logic [PC_W-1:0] ipc_q [DEPTH];
  logic fold_q [DEPTH];
  assign fetch_valid = cnt_q != '0;
  assign pop = fetch_valid & fetch_ready;
  // a dropped request must stay up until the memory acks it
  assign imem_req = reset_n & (drop_q | pop | (cnt_q != (AW+1)'(DEPTH)));
  assign acc = imem_req & imem_ack;
  assign push = acc & ~drop_q & ~redirect_valid;
  assign imem_addr = addr_q;
  assign fetch_instr = instr_q[rd_q];
  assign fetch_pc = ipc_q[rd_q];
  assign fetch_folded = fold_q[rd_q];
`ifdef FETCH_PREDECODE_EN
  logic [PC_W-1:0] li;
  assign li = {{(PC_W-24){imem_rdata[25]}}, imem_rdata[25:2]};
  assign fold = imem_rdata[31:26] == 6'd18;
  assign next_pc = fold ? (imem_rdata[1] ? li : pc_q + li + PC_W'(1)) : pc_q + PC_W'(1);
`else
  assign fold = 1'b0;
  assign next_pc = pc_q + PC_W'(1);
`endif
  always_comb begin
    pc_d = redirect_valid ? redirect_pc : push ? next_pc : pc_q;
    drop_d = redirect_valid ? imem_req & ~imem_ack : drop_q & ~acc;
    addr_d = drop_d ? addr_q : pc_d;
    rd_d = redirect_valid ? '0 : rd_q + AW'(pop);
    wr_d = redirect_valid ? '0 : wr_q + AW'(push);
    cnt_d = redirect_valid ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[wr_q] <= imem_rdata;
      ipc_q[wr_q] <= pc_q;
      fold_q[wr_q] <= fold;
    end
  end
endmodule
